fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction queue between `fetch_stage` and dispatch in the 3-wide R10K pipeline. Accepts up to three `IF_ID_PACKET`s per cycle from fetch, compacts out invalid slots, and presents up to three oldest instructions to dispatch in program order. Drives the per-slot `dis_stall` vector back to fetch. Flushes completely on a taken branch.

## Interface

Parameters:
- `DEPTH`, 8: queue entries; power of two, at least 4.
- `WIDTH`, 3: superscalar width; fixed at 3.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low. `reset==0` at a rising edge clears the block.
- `if_packet_in` in `IF_ID_PACKET [2:0]`: fetch output. Slot 2 is oldest. Per-slot `.valid` qualifies the slot.
- `squash` in 1: taken branch or mispredict flush. Driven from `take_branch`.
- `dis_accept` in 2: number of presented instructions dispatch consumes this cycle, 0..3.
- `dis_packet_out` out `IF_ID_PACKET [2:0]`: slot 2 is the head, slot 1 is head+1, slot 0 is head+2.
- `dis_valid` out 3: `dis_valid[2-k] = (count > k)`.
- `fb_stall` out 3: feeds `fetch_stage.dis_stall`; a 1 marks a slot that cannot be accepted.
- `count` out `$clog2(DEPTH)+1`: current occupancy.

## Operation

- Storage is a circular array with `head` and `tail` pointers, `$clog2(DEPTH)` bits wide. Pointers wrap modulo `DEPTH`. Occupancy is tracked by `count`, so full and empty are never ambiguous.
- `free = DEPTH - count`, computed from registered `count` only. Same-cycle dequeue does not add space.
- `fb_stall` is a thermometer mask from oldest slot:
  - `free >= 3`: `000`
  - `free == 2`: `001`
  - `free == 1`: `011`
  - `free == 0`: `111`
- Enqueue set is the slots where `if_packet_in[i].valid & ~fb_stall[i]`. They are written at `tail`, `tail+1`, … in order slot 2, 1, 0, with invalid slots skipped (compaction). `enq_n` is 0..3.
- Dequeue: `deq_n = min(dis_accept, count, 3)`. Oversized `dis_accept` is clamped and is never an error. `head += deq_n`.
- Dequeue and enqueue in the same cycle update `count_next = count - deq_n + enq_n`.
- Squash has priority over enqueue and dequeue:
  - `head`, `tail` and `count` are set to 0.
  - All same-cycle enqueues are discarded.
- Reset: `head = tail = count = 0`. Storage contents are don't-care. Reset mid-operation behaves the same as squash.
- `dis_packet_out` slots with `dis_valid==0` are forced to an all-zero packet (`.valid=0`).

## Timing

- `dis_packet_out`, `dis_valid`, `fb_stall` and `count` are combinational from registered state only. There is no input-to-output combinational path.
- An instruction enqueued in cycle N is visible on `dis_packet_out` in cycle N+1 at the earliest. Minimum latency is 1.
- An entry dequeued in cycle N is gone from outputs in cycle N+1.
- Squash asserted in cycle N: in cycle N+1 `dis_valid==000`, `count==0`, `fb_stall==000`. Post-branch packets presented in N+1 are enqueued normally.
- Output values while `reset==0` and in the cycle after: `dis_valid=000`, `fb_stall=000`, `count=0`, `dis_packet_out` all-zero.
- Full boundary (`count==DEPTH`):
  - Inputs are fully stalled.
  - If dispatch drains 3 the same cycle, `count` becomes `DEPTH-3`.
  - Fetch may refill in the next cycle.
- Empty boundary: `dis_accept` is ignored.
- Wrap: entries straddling index `DEPTH-1` → 0 are presented in correct order.

## Configuration

- `FETCH_BUFFER_STATS_EN` defined adds two outputs, both reset to 0 and saturating at all-ones:
  - `fb_full_cycles` out 32: cycles with `count==DEPTH`.
  - `fb_squashed` out 32: adds `count` on each squash cycle.
- `FETCH_BUFFER_STATS_EN` undefined: those ports and counters are absent. All other behaviour is identical.

## Test plan

- Reset with `reset=0` for 2 cycles, then release. Require `count=0`, `dis_valid=000`, `fb_stall=000`.
- Sequential fill: present valid `111` with PCs `0xA000/0xA004/0xA008`, `dis_accept=0`.
  - Next cycle: `count=3`, `dis_valid=111`, slot2 PC `0xA000`, slot0 PC `0xA008`.
- Compaction: with empty buffer, present valid `010` with PC `0x40`.
  - Next cycle: `count=1`, `dis_valid=100`, `dis_packet_out[2].PC=0x40`.
- Full/stall with `DEPTH=8`, `dis_accept=0`: three cycles of `111`.
  - Require `count=8` and `fb_stall=111`.
  - After 2 cycles `count=6` and `fb_stall=001`.
  - Then `dis_accept=3` with inputs `111` gives `count=5`.
- Wrap: cycle 24 instructions through with `dis_accept=3` every cycle. The dispatched PC sequence must be strictly `+4` with no gaps or duplicates across the index 7→0 wrap.
- Squash: with `count=5`, assert `squash=1` while presenting `111`. Next cycle `count=0`, `dis_valid=000`. With `FETCH_BUFFER_STATS_EN` defined, `fb_squashed` increases by 5.

Source files
------------

// File: rtl/fetch_buffer.sv
// Fetch-to-dispatch instruction queue: compacting 3-wide enqueue, in-order 3-wide dequeue.
// Optional FETCH_BUFFER_STATS_EN adds full-cycle and squashed-entry counters.
package if_id_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] NPC;
        logic [31:0] PC;
    } IF_ID_PACKET;
endpackage

module fetch_buffer
    import if_id_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  IF_ID_PACKET [WIDTH-1:0]    if_packet_in,
    input  logic                       squash,
    input  logic [1:0]                 dis_accept,
    output IF_ID_PACKET [WIDTH-1:0]    dis_packet_out,
    output logic [WIDTH-1:0]           dis_valid,
    output logic [WIDTH-1:0]           fb_stall,
    output logic [$clog2(DEPTH):0]     count
`ifdef FETCH_BUFFER_STATS_EN
    ,
    output logic [31:0]                fb_full_cycles,
    output logic [31:0]                fb_squashed
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    IF_ID_PACKET mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] free;
    logic [CW-1:0] acc_w;
    logic [CW-1:0] deq_n;
    logic [2:0]    acc;
    logic [1:0]    off1;
    logic [1:0]    off0;
    logic [1:0]    enq_n;
    logic          clear;

    assign clear = !reset || squash;

    // Space is judged from registered occupancy only, so stall never
    // depends on this cycle's dispatch.
    always_comb begin
        free = CW'(DEPTH) - count;
        unique case (1'b1)
            (free >= CW'(3)): fb_stall = 3'b000;
            (free == CW'(2)): fb_stall = 3'b001;
            (free == CW'(1)): fb_stall = 3'b011;
            default:          fb_stall = 3'b111;
        endcase
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            acc[i] = if_packet_in[i].valid & ~fb_stall[i];
        end
        off1  = {1'b0, acc[2]};
        off0  = {1'b0, acc[2]} + {1'b0, acc[1]};
        enq_n = off0 + {1'b0, acc[0]};
        acc_w = CW'(dis_accept);
        deq_n = (acc_w < count) ? acc_w : count;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(deq_n);
            tail  <= tail + PW'(enq_n);
            count <= count - deq_n + CW'(enq_n);
        end
    end

    // Slots land at tail in age order with invalid slots squeezed out.
    always_ff @(posedge clock) begin
        if (!clear) begin
            if (acc[2]) mem[tail] <= if_packet_in[2];
            if (acc[1]) mem[tail + PW'(off1)] <= if_packet_in[1];
            if (acc[0]) mem[tail + PW'(off0)] <= if_packet_in[0];
        end
    end

    always_comb begin
        dis_valid      = '0;
        dis_packet_out = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (count > CW'(k)) begin
                dis_valid[WIDTH-1-k]      = 1'b1;
                dis_packet_out[WIDTH-1-k] = mem[head + PW'(k)];
            end
        end
    end

`ifdef FETCH_BUFFER_STATS_EN
    logic [32:0] sq_sum;

    assign sq_sum = {1'b0, fb_squashed} + 33'(count);

    always_ff @(posedge clock) begin
        if (!reset) begin
            fb_full_cycles <= '0;
            fb_squashed    <= '0;
        end else begin
            if (count == CW'(DEPTH) && fb_full_cycles != '1)
                fb_full_cycles <= fb_full_cycles + 32'd1;
            if (squash)
                fb_squashed <= sq_sum[32] ? '1 : sq_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: reset, fill, compaction, full/stall,
// squash, wrap ordering and mid-operation reset.
module tb_fetch_buffer;
    import if_id_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic squash = 1'b0;
    logic [1:0] dis_accept = 2'd0;
    IF_ID_PACKET [2:0] if_packet_in = '0;
    IF_ID_PACKET [2:0] dis_packet_out;
    logic [2:0] dis_valid;
    logic [2:0] fb_stall;
    logic [3:0] count;
`ifdef FETCH_BUFFER_STATS_EN
    logic [31:0] fb_full_cycles;
    logic [31:0] fb_squashed;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fetch_buffer #(.DEPTH(8), .WIDTH(3)) dut (
        .clock(clock),
        .reset(reset),
        .if_packet_in(if_packet_in),
        .squash(squash),
        .dis_accept(dis_accept),
        .dis_packet_out(dis_packet_out),
        .dis_valid(dis_valid),
        .fb_stall(fb_stall),
        .count(count)
`ifdef FETCH_BUFFER_STATS_EN
        ,
        .fb_full_cycles(fb_full_cycles),
        .fb_squashed(fb_squashed)
`endif
    );

    always #5 clock = ~clock;

    function automatic IF_ID_PACKET mk(input logic v, input logic [31:0] pc);
        IF_ID_PACKET p;
        p.valid = v;
        p.PC    = pc;
        p.NPC   = pc + 32'd4;
        p.inst  = pc ^ 32'h1300_0013;
        return p;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [31:0] p2,
                         input logic [31:0] p1, input logic [31:0] p0,
                         input logic [1:0] acc, input logic sq);
        if_packet_in[2] = mk(v[2], p2);
        if_packet_in[1] = mk(v[1], p1);
        if_packet_in[0] = mk(v[0], p0);
        dis_accept = acc;
        squash = sq;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(3'b000, 0, 0, 0, 2'd0, 1'b0);
        tick;
        tick;
        n_cmp++;
        if (count !== 4'd0) begin
            n_bad++; $display("FAIL rst_count got %0d want 0", count);
        end
        n_cmp++;
        if (dis_valid !== 3'b000) begin
            n_bad++; $display("FAIL rst_valid got %b want 000", dis_valid);
        end
        n_cmp++;
        if (fb_stall !== 3'b000) begin
            n_bad++; $display("FAIL rst_stall got %b want 000", fb_stall);
        end
        reset = 1'b1;
        tick;
        n_cmp++;
        if (count !== 4'd0 || dis_valid !== 3'b000) begin
            n_bad++; $display("FAIL rst_release got %0d/%b want 0/000", count, dis_valid);
        end
        n_cmp++;
        if (dis_packet_out !== '0) begin
            n_bad++; $display("FAIL rst_pkt got %h want 0", dis_packet_out);
        end
    endtask

    task automatic test_fill;
        drive(3'b111, 32'hA000, 32'hA004, 32'hA008, 2'd0, 1'b0);
        tick;
        drive(3'b000, 0, 0, 0, 2'd0, 1'b0);
        n_cmp++;
        if (count !== 4'd3) begin
            n_bad++; $display("FAIL fill_count got %0d want 3", count);
        end
        n_cmp++;
        if (dis_valid !== 3'b111) begin
            n_bad++; $display("FAIL fill_valid got %b want 111", dis_valid);
        end
        n_cmp++;
        if (dis_packet_out[2].PC !== 32'hA000) begin
            n_bad++; $display("FAIL fill_pc2 got %h want a000", dis_packet_out[2].PC);
        end
        n_cmp++;
        if (dis_packet_out[1].PC !== 32'hA004) begin
            n_bad++; $display("FAIL fill_pc1 got %h want a004", dis_packet_out[1].PC);
        end
        n_cmp++;
        if (dis_packet_out[0] !== mk(1'b1, 32'hA008)) begin
            n_bad++; $display("FAIL fill_pkt0 got %h want %h", dis_packet_out[0], mk(1'b1, 32'hA008));
        end
        dis_accept = 2'd3;
        tick;
        dis_accept = 2'd0;
        n_cmp++;
        if (count !== 4'd0 || dis_packet_out !== '0) begin
            n_bad++; $display("FAIL drain got %0d/%h want 0/0", count, dis_packet_out);
        end
    endtask

    task automatic test_compaction;
        drive(3'b010, 32'h3C, 32'h40, 32'h44, 2'd0, 1'b0);
        tick;
        drive(3'b000, 0, 0, 0, 2'd0, 1'b0);
        n_cmp++;
        if (count !== 4'd1 || dis_valid !== 3'b100) begin
            n_bad++; $display("FAIL cmp_one got %0d/%b want 1/100", count, dis_valid);
        end
        n_cmp++;
        if (dis_packet_out[2].PC !== 32'h40) begin
            n_bad++; $display("FAIL cmp_pc got %h want 40", dis_packet_out[2].PC);
        end
        n_cmp++;
        if (dis_packet_out[1] !== '0) begin
            n_bad++; $display("FAIL cmp_zero got %h want 0", dis_packet_out[1]);
        end
        drive(3'b101, 32'h100, 32'h104, 32'h108, 2'd3, 1'b0);
        tick;
        drive(3'b000, 0, 0, 0, 2'd0, 1'b0);
        n_cmp++;
        if (count !== 4'd2 || dis_valid !== 3'b110) begin
            n_bad++; $display("FAIL cmp_two got %0d/%b want 2/110", count, dis_valid);
        end
        n_cmp++;
        if (dis_packet_out[2].PC !== 32'h100 || dis_packet_out[1].PC !== 32'h108) begin
            n_bad++; $display("FAIL cmp_order got %h/%h want 100/108",
                              dis_packet_out[2].PC, dis_packet_out[1].PC);
        end
        dis_accept = 2'd3;
        tick;
        dis_accept = 2'd0;
        n_cmp++;
        if (count !== 4'd0) begin
            n_bad++; $display("FAIL cmp_clamp got %0d want 0", count);
        end
        dis_accept = 2'd3;
        tick;
        dis_accept = 2'd0;
        n_cmp++;
        if (count !== 4'd0) begin
            n_bad++; $display("FAIL empty_accept got %0d want 0", count);
        end
    endtask

    task automatic test_full_squash;
        logic [31:0] p;
        p = 32'h1000;
        drive(3'b111, p, p + 4, p + 8, 2'd0, 1'b0);
        tick;
        drive(3'b111, p + 12, p + 16, p + 20, 2'd0, 1'b0);
        tick;
        n_cmp++;
        if (count !== 4'd6 || fb_stall !== 3'b001) begin
            n_bad++; $display("FAIL full_six got %0d/%b want 6/001", count, fb_stall);
        end
        drive(3'b111, p + 24, p + 28, p + 32, 2'd0, 1'b0);
        tick;
        n_cmp++;
        if (count !== 4'd8 || fb_stall !== 3'b111) begin
            n_bad++; $display("FAIL full_eight got %0d/%b want 8/111", count, fb_stall);
        end
        drive(3'b111, p + 36, p + 40, p + 44, 2'd3, 1'b0);
        tick;
        drive(3'b000, 0, 0, 0, 2'd0, 1'b0);
        n_cmp++;
        if (count !== 4'd5 || fb_stall !== 3'b000) begin
            n_bad++; $display("FAIL full_drain got %0d/%b want 5/000", count, fb_stall);
        end
        n_cmp++;
        if (dis_packet_out[2].PC !== p + 12 || dis_packet_out[0].PC !== p + 20) begin
            n_bad++; $display("FAIL full_head got %h/%h want %h/%h",
                              dis_packet_out[2].PC, dis_packet_out[0].PC, p + 12, p + 20);
        end
        drive(3'b110, p + 100, p + 104, p + 108, 2'd0, 1'b0);
        tick;
        n_cmp++;
        if (count !== 4'd7 || fb_stall !== 3'b011) begin
            n_bad++; $display("FAIL free_one got %0d/%b want 7/011", count, fb_stall);
        end
        drive(3'b000, 0, 0, 0, 2'd2, 1'b0);
        tick;
        n_cmp++;
        if (count !== 4'd5 || dis_packet_out[2].PC !== p + 20
            || dis_packet_out[0].PC !== p + 28) begin
            n_bad++; $display("FAIL deq_two got %0d/%h/%h want 5/%h/%h", count,
                              dis_packet_out[2].PC, dis_packet_out[0].PC, p + 20, p + 28);
        end
        drive(3'b111, p + 200, p + 204, p + 208, 2'd3, 1'b1);
        tick;
        drive(3'b000, 0, 0, 0, 2'd0, 1'b0);
        n_cmp++;
        if (count !== 4'd0 || dis_valid !== 3'b000 || fb_stall !== 3'b000) begin
            n_bad++; $display("FAIL squash got %0d/%b/%b want 0/000/000",
                              count, dis_valid, fb_stall);
        end
`ifdef FETCH_BUFFER_STATS_EN
        n_cmp++;
        if (fb_squashed !== 32'd5) begin
            n_bad++; $display("FAIL stat_squash got %0d want 5", fb_squashed);
        end
        n_cmp++;
        if (fb_full_cycles !== 32'd1) begin
            n_bad++; $display("FAIL stat_full got %0d want 1", fb_full_cycles);
        end
`endif
        drive(3'b111, 32'h2000, 32'h2004, 32'h2008, 2'd0, 1'b0);
        tick;
        drive(3'b000, 0, 0, 0, 2'd3, 1'b0);
        n_cmp++;
        if (count !== 4'd3 || dis_packet_out[2].PC !== 32'h2000) begin
            n_bad++; $display("FAIL post_squash got %0d/%h want 3/2000",
                              count, dis_packet_out[2].PC);
        end
        tick;
        dis_accept = 2'd0;
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pc;
        int sent;
        int got;
        exp_pc = 32'h8000;
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                if (dis_valid[2-k]) begin
                    n_cmp++;
                    if (dis_packet_out[2-k].PC !== exp_pc) begin
                        n_bad++; $display("FAIL wrap_pc got %h want %h",
                                          dis_packet_out[2-k].PC, exp_pc);
                    end
                    exp_pc = exp_pc + 32'd4;
                    got++;
                end
            end
            if (sent < 24) begin
                drive(3'b111, 32'h8000 + 4 * sent, 32'h8004 + 4 * sent,
                      32'h8008 + 4 * sent, 2'd3, 1'b0);
                sent += 3;
            end else begin
                drive(3'b000, 0, 0, 0, 2'd3, 1'b0);
            end
            tick;
        end
        dis_accept = 2'd0;
        n_cmp++;
        if (got != 24 || count !== 4'd0) begin
            n_bad++; $display("FAIL wrap_total got %0d/%0d want 24/0", got, count);
        end
    endtask

    task automatic test_reset_mid;
        drive(3'b111, 32'h9000, 32'h9004, 32'h9008, 2'd0, 1'b0);
        tick;
        reset = 1'b0;
        drive(3'b111, 32'h900C, 32'h9010, 32'h9014, 2'd0, 1'b0);
        tick;
        drive(3'b000, 0, 0, 0, 2'd0, 1'b0);
        n_cmp++;
        if (count !== 4'd0 || dis_valid !== 3'b000 || fb_stall !== 3'b000) begin
            n_bad++; $display("FAIL mid_reset got %0d/%b/%b want 0/000/000",
                              count, dis_valid, fb_stall);
        end
`ifdef FETCH_BUFFER_STATS_EN
        n_cmp++;
        if (fb_squashed !== 32'd0 || fb_full_cycles !== 32'd0) begin
            n_bad++; $display("FAIL mid_stats got %0d/%0d want 0/0",
                              fb_squashed, fb_full_cycles);
        end
`endif
        reset = 1'b1;
        tick;
        n_cmp++;
        if (count !== 4'd0 || dis_packet_out !== '0) begin
            n_bad++; $display("FAIL mid_release got %0d/%h want 0/0", count, dis_packet_out);
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_compaction;
        test_full_squash;
        test_wrap;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
